// File: rtl/fp_sched_pkg.sv
// rtl/fp_sched_pkg.sv - shared types, op codes and constants for the FP op scheduler
package fp_sched_pkg;

    typedef enum logic [2:0] {IDLE, CLASSIFY, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} fp_class_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam int FLAG_DENORM  = 0;
    localparam int FLAG_SPECIAL = 1;
    localparam int FLAG_INVALID = 2;
    localparam int FLAG_TIMEOUT = 3;

    // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
    function automatic logic [63:0] qnan_word(input int exp_w, input int mant_w);
        return (((64'd1 << exp_w) - 64'd1) << mant_w) | (64'd1 << (mant_w - 1));
    endfunction

endpackage

// File: rtl/fp_special_resolver.sv
// rtl/fp_special_resolver.sv - resolves IEEE special-case operand pairs without the core
module fp_special_resolver
    import fp_sched_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    localparam int W         = EXP_WIDTH + MANT_WIDTH + 1
) (
    input  fp_class_t      cls_a,
    input  fp_class_t      cls_b,
    input  logic           sign_a,
    input  logic           sign_b,
    input  logic           quiet_a,
    input  logic           quiet_b,
    input  logic [1:0]     op,
    output logic           hit,
    output logic [W-1:0]   result,
    output logic           invalid,
    output logic           denorm_in
);

    localparam logic [W-1:0] QNAN     = W'(qnan_word(EXP_WIDTH, MANT_WIDTH));
    localparam logic [W-2:0] INF_MAG  = {{EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};

    logic eff_sign_b;
    logic prod_sign;

    assign denorm_in = (cls_a == DENORM) || (cls_b == DENORM);

    always_comb begin
        hit        = 1'b0;
        result     = '0;
        invalid    = 1'b0;
        eff_sign_b = sign_b ^ (op == OP_SUB);
        prod_sign  = sign_a ^ sign_b;
        if (cls_a == NAN || cls_b == NAN) begin
            hit     = 1'b1;
            result  = QNAN;
            invalid = (cls_a == NAN && !quiet_a) || (cls_b == NAN && !quiet_b);
        end else if (op == OP_MUL) begin
            if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
                hit     = 1'b1;
                result  = QNAN;
                invalid = 1'b1;
            end else if (cls_a == INF || cls_b == INF) begin
                hit    = 1'b1;
                result = {prod_sign, INF_MAG};
            end else if (cls_a == ZERO || cls_b == ZERO) begin
                hit    = 1'b1;
                result = {prod_sign, {(W-1){1'b0}}};
            end
        end else begin
            // Reserved op code lands here and behaves as ADD.
            if (cls_a == INF && cls_b == INF) begin
                hit = 1'b1;
                if (sign_a != eff_sign_b) begin
                    result  = QNAN;
                    invalid = 1'b1;
                end else begin
                    result = {sign_a, INF_MAG};
                end
            end else if (cls_a == INF) begin
                hit    = 1'b1;
                result = {sign_a, INF_MAG};
            end else if (cls_b == INF) begin
                hit    = 1'b1;
                result = {eff_sign_b, INF_MAG};
            end
        end
    end

endmodule

// File: rtl/fp_op_scheduler.sv
// rtl/fp_op_scheduler.sv - single-request FP front-end: classify, resolve specials, issue to core
module fp_op_scheduler
    import fp_sched_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MANT_WIDTH     = 23,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int W             = EXP_WIDTH + MANT_WIDTH + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_op,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_result,
    output logic [3:0]     out_flags,
    output logic           core_req,
    input  logic           core_ack,
    output logic [1:0]     core_op,
    output logic [W-1:0]   core_a,
    output logic [W-1:0]   core_b,
    input  logic           core_done,
    input  logic [W-1:0]   core_result,
    output logic           core_abort,
    output logic           busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] QNAN = W'(qnan_word(EXP_WIDTH, MANT_WIDTH));

    function automatic fp_class_t classify(input logic [W-1:0] x);
        logic [EXP_WIDTH-1:0]  e;
        logic [MANT_WIDTH-1:0] m;
        e = x[W-2 -: EXP_WIDTH];
        m = x[MANT_WIDTH-1:0];
        if (e == '0) return (m == '0) ? ZERO : DENORM;
        if (&e)      return (m == '0) ? INF : NAN;
        return NORMAL;
    endfunction

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          den_q;
    logic          expired;
    logic          hit, invalid, denorm_in;
    logic [W-1:0]  spec_result;
    logic [3:0]    spec_flags, done_flags, tmo_flags;

    fp_special_resolver #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_resolver (
        .cls_a     (classify(core_a)),
        .cls_b     (classify(core_b)),
        .sign_a    (core_a[W-1]),
        .sign_b    (core_b[W-1]),
        .quiet_a   (core_a[MANT_WIDTH-1]),
        .quiet_b   (core_b[MANT_WIDTH-1]),
        .op        (core_op),
        .hit       (hit),
        .result    (spec_result),
        .invalid   (invalid),
        .denorm_in (denorm_in)
    );

    assign out_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign expired   = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        spec_flags               = '0;
        spec_flags[FLAG_SPECIAL] = 1'b1;
        spec_flags[FLAG_INVALID] = invalid;
        spec_flags[FLAG_DENORM]  = denorm_in;
        done_flags               = '0;
        done_flags[FLAG_DENORM]  = den_q;
        tmo_flags                = done_flags;
        tmo_flags[FLAG_TIMEOUT]  = 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        core_req   = 1'b0;
        core_abort = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CLASSIFY;
            end
            CLASSIFY: state_nxt = hit ? RESP : ISSUE;
            ISSUE: begin
                core_req = 1'b1;
                if (core_ack) state_nxt = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle takes precedence over the abort.
                if (core_done) begin
                    state_nxt = RESP;
                end else if (expired) begin
                    core_abort = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            core_a     <= '0;
            core_b     <= '0;
            core_op    <= '0;
            out_result <= '0;
            out_flags  <= '0;
            cnt        <= '0;
            den_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    core_a  <= in_a;
                    core_b  <= in_b;
                    core_op <= in_op;
                end
                CLASSIFY: begin
                    den_q <= denorm_in;
                    if (hit) begin
                        out_result <= spec_result;
                        out_flags  <= spec_flags;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (core_done) begin
                        out_result <= core_result;
                        out_flags  <= done_flags;
                    end else if (expired) begin
                        out_result <= QNAN;
                        out_flags  <= tmo_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_op_scheduler.sv
// tb/tb_fp_op_scheduler.sv - directed self-checking bench for fp_op_scheduler
module tb_fp_op_scheduler;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        core_req, core_ack;
    logic [1:0]  core_op;
    logic [31:0] core_a, core_b;
    logic        core_done;
    logic [31:0] core_result;
    logic        core_abort, busy;

    int   checks = 0;
    int   errors = 0;
    logic req_seen;

    fp_op_scheduler #(.EXP_WIDTH(8), .MANT_WIDTH(23), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .core_req(core_req), .core_ack(core_ack), .core_op(core_op), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result), .core_abort(core_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (core_req === 1'b1) req_seen = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    task automatic special(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [31:0] exp_res, input logic [3:0] exp_fl);
        req_seen = 1'b0;
        send(a, b, op);
        check({tag, "_early"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_res"},   64'(out_result), 64'(exp_res));
        check({tag, "_flags"}, 64'(out_flags), 64'(exp_fl));
        check({tag, "_noreq"}, 64'(req_seen), 64'd0);
        release_out(tag);
    endtask

    task automatic core_path(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] op, input int done_at, input logic [31:0] cres,
                             input logic [31:0] exp_res, input logic [3:0] exp_fl,
                             input int exp_abort_at, input int exp_rsp_at);
        int abort_at = 0;
        int rsp_at = 0;
        send(a, b, op);
        @(posedge clk); #1;
        check({tag, "_req"},  64'(core_req), 64'd1);
        check({tag, "_ca"},   64'(core_a), 64'(a));
        check({tag, "_cb"},   64'(core_b), 64'(b));
        check({tag, "_cop"},  64'(core_op), 64'(op));
        core_ack = 1'b1;
        @(posedge clk); #1;
        core_ack = 1'b0;
        for (int c = 1; c <= T + 4; c++) begin
            core_done   = (c == done_at);
            core_result = cres;
            #4;
            if (core_abort === 1'b1) abort_at = c;
            @(posedge clk); #1;
            core_done = 1'b0;
            if (out_valid === 1'b1) begin
                rsp_at = c;
                break;
            end
        end
        check({tag, "_abort"}, 64'(abort_at), 64'(exp_abort_at));
        check({tag, "_lat"},   64'(rsp_at), 64'(exp_rsp_at));
        check({tag, "_res"},   64'(out_result), 64'(exp_res));
        check({tag, "_flags"}, 64'(out_flags), 64'(exp_fl));
        release_out(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
        out_ready = 1'b0; core_ack = 1'b0; core_done = 1'b0; core_result = '0;
        req_seen = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready",  64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_core_req",  64'(core_req), 64'd0);
        check("rst_abort",     64'(core_abort), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_result",    64'(out_result), 64'd0);
        check("rst_flags",     64'(out_flags), 64'd0);
        check("rst_core_a",    64'(core_a), 64'd0);

        core_path("add_core", 32'h3F800000, 32'h40000000, 2'b00, 3, 32'h40400000,
                  32'h40400000, 4'b0000, 0, 3);
        core_path("add_denorm", 32'h00000001, 32'h3F800000, 2'b00, 2, 32'h3F800000,
                  32'h3F800000, 4'b0001, 0, 2);
        core_path("timeout", 32'h3F800000, 32'h3F800000, 2'b00, 0, 32'h12345678,
                  32'h7FC00000, 4'b1000, T, T);
        core_path("done_expiry", 32'h3F800000, 32'h3F800000, 2'b00, T, 32'h40000000,
                  32'h40000000, 4'b0000, 0, T);

        special("inf_minus_inf", 32'h7F800000, 32'hFF800000, 2'b00, 32'h7FC00000, 4'b0110);
        special("sub_inf",       32'h7F800000, 32'h3F800000, 2'b01, 32'h7F800000, 4'b0010);
        special("mul_inf_zero",  32'hFF800000, 32'h00000000, 2'b10, 32'h7FC00000, 4'b0110);
        special("mul_snan",      32'h7FA00000, 32'h3F800000, 2'b10, 32'h7FC00000, 4'b0110);
        special("mul_qnan",      32'h7FC00001, 32'h3F800000, 2'b10, 32'h7FC00000, 4'b0010);
        special("mul_negzero",   32'h80000000, 32'h3F800000, 2'b10, 32'h80000000, 4'b0010);
        special("add_neg_inf_b", 32'h3F800000, 32'hFF800000, 2'b00, 32'hFF800000, 4'b0010);
        special("sub_inf_inf",   32'h7F800000, 32'h7F800000, 2'b01, 32'h7FC00000, 4'b0110);
        special("rsvd_op_inf",   32'hFF800000, 32'h3F800000, 2'b11, 32'hFF800000, 4'b0010);

        send(32'h7F800000, 32'hFF800000, 2'b00);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",    64'(out_valid), 64'd1);
            check("stall_res",      64'(out_result), 64'h7FC00000);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        release_out("stall");

        send(32'h3F800000, 32'h40000000, 2'b00);
        @(posedge clk); #1;
        core_ack = 1'b1;
        @(posedge clk); #1;
        core_ack = 1'b0;
        @(posedge clk); #1;
        check("wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_req",   64'(core_req), 64'd0);
        check("midrst_busy",  64'(busy), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_abort", 64'(core_abort), 64'd0);
        rst_n = 1'b1;
        check("midrst_ready", 64'(in_ready), 64'd1);
        special("post_rst", 32'h7F800000, 32'h3F800000, 2'b01, 32'h7F800000, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
